// File: rtl/serial_mmio_bridge.sv
// rtl/serial_mmio_bridge.sv - memory-mapped multi-channel serial bridge with per-channel RX/TX FIFOs
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   addr_in[3:2]/[5:4]         register select / channel select for CPU accesses
//   rden_in, wren_in           one-cycle CPU load / store strobes
//   wdata_in, rdata_out        CPU store data / registered load data
//   serial_in, serial_valid_in RX bytes and per-channel availability
//   serial_rden_out            per-channel pulse: RX byte consumed
//   serial_ready_in            per-channel TX sink ready
//   serial_out, serial_wren_out registered TX bytes and per-channel valid pulse
module serial_mmio_bridge #(
  parameter int CHANNELS   = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    addr_in,
  input  logic                           rden_in,
  input  logic                           wren_in,
  input  logic [31:0]                    wdata_in,
  output logic [31:0]                    rdata_out,
  input  logic [CHANNELS*DATA_WIDTH-1:0] serial_in,
  input  logic [CHANNELS-1:0]            serial_valid_in,
  output logic [CHANNELS-1:0]            serial_rden_out,
  input  logic [CHANNELS-1:0]            serial_ready_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] serial_out,
  output logic [CHANNELS-1:0]            serial_wren_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RX_IDLE, RX_ACK}  rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  logic [1:0]                 reg_sel;
  logic [1:0]                 ch_sel;
  logic [CHANNELS-1:0][31:0]  ch_rdata;
  logic [31:0]                rd_mux;
  logic                       unused_ok;

  assign reg_sel   = addr_in[3:2];
  assign ch_sel    = addr_in[5:4];
  assign unused_ok = ^{addr_in[31:6], addr_in[1:0], wdata_in};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic                  hit;
    logic                  rd_data, wr_data, wr_status, wr_ctrl;
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]         rx_wp, rx_rp, tx_wp, tx_rp;
    logic [CW-1:0]         rx_cnt, tx_cnt;
    logic                  rx_empty, rx_full, tx_empty, tx_full;
    logic                  rx_push, rx_pop, tx_push, tx_pop;
    logic                  rx_ack, tx_send;
    logic                  rx_uf, tx_of;
    logic [1:0]            ctrl;
    logic [DATA_WIDTH-1:0] tx_byte;
    logic [7:0]            rx_cnt8, tx_cnt8;
    logic [31:0]           rd_val;
    rx_state_t             rx_state, rx_next;
    tx_state_t             tx_state, tx_next;

    // Out-of-range channel numbers never match any generated channel, so
    // such accesses touch no state and read back as zero.
    assign hit       = (ch_sel == 2'(c));
    assign rd_data   = rden_in && hit && (reg_sel == 2'd0);
    assign wr_data   = wren_in && hit && (reg_sel == 2'd0);
    assign wr_status = wren_in && hit && (reg_sel == 2'd1);
    assign wr_ctrl   = wren_in && hit && (reg_sel == 2'd2);

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));

    // Full/empty are judged on the pre-edge count: a push into a full FIFO
    // is dropped and a pop from an empty FIFO is rejected even if the other
    // side moves in the same cycle.
    assign rx_pop  = rd_data && !rx_empty;
    assign tx_push = wr_data && !tx_full;

    always_comb begin
      rx_next = rx_state;
      rx_push = 1'b0;
      rx_ack  = 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (serial_valid_in[c] && !rx_full && ctrl[0]) begin
            rx_next = RX_ACK;
            rx_push = 1'b1;
          end
        end
        RX_ACK: begin
          rx_ack  = 1'b1;
          rx_next = RX_IDLE;
        end
        default: rx_next = RX_IDLE;
      endcase
    end

    always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      tx_send = 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (serial_ready_in[c] && !tx_empty && ctrl[1]) begin
            tx_next = TX_SEND;
            tx_pop  = 1'b1;
          end
        end
        TX_SEND: begin
          tx_send = 1'b1;
          tx_next = TX_IDLE;
        end
        default: tx_next = TX_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rx_state <= RX_IDLE;
        tx_state <= TX_IDLE;
        rx_wp    <= '0;
        rx_rp    <= '0;
        tx_wp    <= '0;
        tx_rp    <= '0;
        rx_cnt   <= '0;
        tx_cnt   <= '0;
        rx_uf    <= 1'b0;
        tx_of    <= 1'b0;
        ctrl     <= 2'b11;
        tx_byte  <= '0;
      end else begin
        rx_state <= rx_next;
        tx_state <= tx_next;
        if (rx_push) rx_wp <= rx_wp + 1'b1;
        if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        case ({rx_push, rx_pop})
          2'b10:   rx_cnt <= rx_cnt + 1'b1;
          2'b01:   rx_cnt <= rx_cnt - 1'b1;
          default: ;
        endcase
        case ({tx_push, tx_pop})
          2'b10:   tx_cnt <= tx_cnt + 1'b1;
          2'b01:   tx_cnt <= tx_cnt - 1'b1;
          default: ;
        endcase
        if (tx_pop) tx_byte <= tx_mem[tx_rp];
        // A new error event wins over a same-cycle W1C clear.
        if (rd_data && rx_empty)             rx_uf <= 1'b1;
        else if (wr_status && wdata_in[2])   rx_uf <= 1'b0;
        if (wr_data && tx_full)              tx_of <= 1'b1;
        else if (wr_status && wdata_in[3])   tx_of <= 1'b0;
        if (wr_ctrl) ctrl <= wdata_in[1:0];
      end
    end

    always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp] <= serial_in[c*DATA_WIDTH +: DATA_WIDTH];
      if (tx_push) tx_mem[tx_wp] <= wdata_in[DATA_WIDTH-1:0];
    end

    always_comb begin
      rx_cnt8 = '0;
      tx_cnt8 = '0;
      rx_cnt8[CW-1:0] = rx_cnt;
      tx_cnt8[CW-1:0] = tx_cnt;
      rd_val = '0;
      case (reg_sel)
        2'd0:    rd_val = rx_empty ? 32'h0 : 32'(rx_mem[rx_rp]);
        2'd1:    rd_val = {8'h00, tx_cnt8, rx_cnt8, 4'h0, tx_of, rx_uf, !tx_full, !rx_empty};
        2'd2:    rd_val = {30'h0, ctrl};
        default: rd_val = '0;
      endcase
    end

    assign ch_rdata[c]                          = rd_val;
    assign serial_rden_out[c]                   = rx_ack;
    assign serial_wren_out[c]                   = tx_send;
    assign serial_out[c*DATA_WIDTH +: DATA_WIDTH] = tx_byte;
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_sel == 2'(c)) rd_mux = ch_rdata[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        rdata_out <= '0;
    else if (rden_in) rdata_out <= rd_mux;
  end

endmodule

// File: tb/tb_serial_mmio_bridge.sv
// tb/tb_serial_mmio_bridge.sv - randomized bench for serial_mmio_bridge with queue-based reference model
module tb_serial_mmio_bridge;

  localparam int CH    = 2;
  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   addr, wdata, rdata;
  logic          rden, wren;
  logic [CH*DW-1:0] sin, sout;
  logic [CH-1:0] svalid, sready, srden, swren;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  rx_q [CH][$];
  logic [7:0]  tx_q [CH][$];
  logic        m_uf   [CH];
  logic        m_of   [CH];
  logic [1:0]  m_ctrl [CH];
  logic        m_ack  [CH];
  logic        m_send [CH];
  logic [7:0]  m_sout [CH];
  logic [31:0] m_rdata;
  int          pulses;

  always #5 clk = ~clk;

  serial_mmio_bridge #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .addr_in         (addr),
    .rden_in         (rden),
    .wren_in         (wren),
    .wdata_in        (wdata),
    .rdata_out       (rdata),
    .serial_in       (sin),
    .serial_valid_in (svalid),
    .serial_rden_out (srden),
    .serial_ready_in (sready),
    .serial_out      (sout),
    .serial_wren_out (swren)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status(input int c);
    logic [31:0] s;
    s = '0;
    s[0]     = (rx_q[c].size() != 0);
    s[1]     = (tx_q[c].size() != DEPTH);
    s[2]     = m_uf[c];
    s[3]     = m_of[c];
    s[15:8]  = 8'(rx_q[c].size());
    s[23:16] = 8'(tx_q[c].size());
    return s;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      rx_q[c].delete();
      tx_q[c].delete();
      m_uf[c] = 0; m_of[c] = 0; m_ctrl[c] = 2'b11;
      m_ack[c] = 0; m_send[c] = 0; m_sout[c] = 0;
    end
    m_rdata = 0;
  endtask

  // One clock of the bridge's rules, using the inputs currently driven.
  task automatic model_step();
    int ch, rg;
    bit ok;
    bit rx_pop[CH], rx_push[CH], tx_pop[CH], tx_push[CH];
    bit set_uf[CH], set_of[CH], clr_uf[CH], clr_of[CH], wr_ctrl[CH];
    if (reset) begin
      model_reset();
      return;
    end
    ch = int'(addr[5:4]);
    rg = int'(addr[3:2]);
    ok = (ch < CH);
    for (int c = 0; c < CH; c++) begin
      rx_pop[c] = 0; rx_push[c] = 0; tx_pop[c] = 0; tx_push[c] = 0;
      set_uf[c] = 0; set_of[c] = 0; clr_uf[c] = 0; clr_of[c] = 0; wr_ctrl[c] = 0;
    end
    if (rden) begin
      m_rdata = 0;
      if (ok) begin
        case (rg)
          0: if (rx_q[ch].size() > 0) begin m_rdata = 32'(rx_q[ch][0]); rx_pop[ch] = 1; end
             else set_uf[ch] = 1;
          1: m_rdata = model_status(ch);
          2: m_rdata = 32'(m_ctrl[ch]);
          default: m_rdata = 0;
        endcase
      end
    end
    if (wren && ok) begin
      case (rg)
        0: if (tx_q[ch].size() == DEPTH) set_of[ch] = 1; else tx_push[ch] = 1;
        1: begin clr_uf[ch] = wdata[2]; clr_of[ch] = wdata[3]; end
        2: wr_ctrl[ch] = 1;
        default: ;
      endcase
    end
    for (int c = 0; c < CH; c++) begin
      rx_push[c] = !m_ack[c] && svalid[c] && (rx_q[c].size() < DEPTH) && m_ctrl[c][0];
      tx_pop[c]  = !m_send[c] && sready[c] && (tx_q[c].size() > 0) && m_ctrl[c][1];
    end
    for (int c = 0; c < CH; c++) begin
      if (rx_pop[c])  void'(rx_q[c].pop_front());
      if (rx_push[c]) rx_q[c].push_back(sin[c*DW +: DW]);
      if (tx_pop[c])  m_sout[c] = tx_q[c].pop_front();
      if (tx_push[c]) tx_q[c].push_back(wdata[7:0]);
      if (clr_uf[c]) m_uf[c] = 0;
      if (set_uf[c]) m_uf[c] = 1;
      if (clr_of[c]) m_of[c] = 0;
      if (set_of[c]) m_of[c] = 1;
      if (wr_ctrl[c]) m_ctrl[c] = wdata[1:0];
      m_ack[c]  = rx_push[c];
      m_send[c] = tx_pop[c];
    end
  endtask

  task automatic compare();
    check_eq("rdata_out", rdata, m_rdata);
    for (int c = 0; c < CH; c++) begin
      check_eq($sformatf("serial_rden_out[%0d]", c), 32'(srden[c]), 32'(m_ack[c]));
      check_eq($sformatf("serial_wren_out[%0d]", c), 32'(swren[c]), 32'(m_send[c]));
      check_eq($sformatf("serial_out[%0d]", c), 32'(sout[c*DW +: DW]), 32'(m_sout[c]));
    end
  endtask

  // Inputs are set at the falling edge; the model advances with the rising
  // edge and outputs are compared at the next falling edge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic cpu_load(input logic [31:0] a);
    addr = a; rden = 1;
    step();
    rden = 0;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wren = 1;
    step();
    wren = 0;
  endtask

  initial begin
    reset = 1; addr = 0; wdata = 0; rden = 0; wren = 0;
    sin = 0; svalid = 0; sready = 0;
    model_reset();
    step();
    step();
    reset = 0;

    // Reset state
    cpu_load(32'h4);
    check_eq("reset_status", rdata, 32'h2);
    cpu_load(32'h8);
    check_eq("reset_control", rdata, 32'h3);

    // RX at peak rate: valid held three cycles gives two pulses
    sin = 16'h0041; svalid = 2'b01; pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (srden[0]) pulses++;
    end
    svalid = 0;
    check_eq("rx_pulse_count", 32'(pulses), 32'd2);
    step();
    cpu_load(32'h4);
    check_eq("rx_count_2", 32'(rdata[15:8]), 32'd2);
    cpu_load(32'h0);
    check_eq("rx_data", rdata, 32'h41);

    // TX on channel 1 held off by ready, then drained in order
    cpu_store(32'h10, 32'h5A);
    cpu_store(32'h10, 32'h5B);
    check_eq("tx_no_wren", 32'(swren), 32'h0);
    cpu_load(32'h14);
    check_eq("tx_count_2", 32'(rdata[23:16]), 32'd2);
    sready = 2'b10;
    step();
    check_eq("tx_first_wren", 32'(swren[1]), 32'd1);
    check_eq("tx_first_byte", 32'(sout[15:8]), 32'h5A);
    step();
    check_eq("tx_gap", 32'(swren[1]), 32'd0);
    step();
    check_eq("tx_second_wren", 32'(swren[1]), 32'd1);
    check_eq("tx_second_byte", 32'(sout[15:8]), 32'h5B);
    step();
    sready = 0;

    // TX overflow on channel 0 and W1C clear
    for (int i = 0; i <= DEPTH; i++) cpu_store(32'h0, 32'h80 + 32'(i));
    cpu_load(32'h4);
    check_eq("ovf_bit3", 32'(rdata[3]), 32'd1);
    check_eq("ovf_bit1", 32'(rdata[1]), 32'd0);
    check_eq("ovf_tx_count", 32'(rdata[23:16]), 32'd8);
    cpu_store(32'h4, 32'h8);
    cpu_load(32'h4);
    check_eq("ovf_cleared", 32'(rdata[3]), 32'd0);
    check_eq("ovf_count_kept", 32'(rdata[23:16]), 32'd8);
    sready = 2'b01;
    for (int i = 0; i < 2 * DEPTH + 1; i++) step();
    sready = 0;

    // Underflow, then simultaneous CPU pop and serial push on a 1-entry FIFO
    cpu_load(32'h0);
    check_eq("last_rx_byte", rdata, 32'h41);
    cpu_load(32'h0);
    check_eq("underflow_data", rdata, 32'h0);
    cpu_load(32'h4);
    check_eq("underflow_bit2", 32'(rdata[2]), 32'd1);
    cpu_store(32'h4, 32'h4);
    sin = 16'h0011; svalid = 2'b01;
    step();
    svalid = 0;
    step();
    addr = 32'h0; rden = 1; sin = 16'h0022; svalid = 2'b01;
    step();
    rden = 0; svalid = 0;
    check_eq("simul_pop_data", rdata, 32'h11);
    step();
    cpu_load(32'h4);
    check_eq("simul_count", 32'(rdata[15:8]), 32'd1);
    cpu_load(32'h0);
    check_eq("simul_next_byte", rdata, 32'h22);

    // Reset in the middle of an ACK with three entries queued
    sin = 16'h0033; svalid = 2'b01;
    for (int i = 0; i < 5; i++) step();
    check_eq("pre_reset_ack", 32'(srden[0]), 32'd1);
    reset = 1; svalid = 0;
    step();
    reset = 0;
    check_eq("post_reset_rden", 32'(srden[0]), 32'd0);
    cpu_load(32'h4);
    check_eq("post_reset_status", rdata, 32'h2);
    cpu_load(32'h30);
    check_eq("absent_channel", rdata, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 399) == 0);
      addr   = {26'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      rden   = ($urandom_range(0, 2) == 0);
      wren   = ($urandom_range(0, 2) == 0);
      wdata  = $urandom;
      if (addr[3:2] == 2'd2 && $urandom_range(0, 1) == 0) wdata[1:0] = 2'b11;
      sin    = 16'($urandom);
      svalid = 2'($urandom);
      sready = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_mmio_bridge.md
Name: serial_mmio_bridge

Overview:
- Memory-mapped, multi-channel serial I/O bridge with per-channel RX and TX FIFOs. It is the parametrised successor to the single-byte serial path in the memory stage.
- It sits behind the memory stage's load/store decode. CPU loads and stores target the bridge's register window; serial producers and consumers attach on the far side.
- FIFOs decouple CPU timing from serial handshakes. Sticky error flags and occupancy counters are visible in a status register.

Parameters:
- CHANNELS, 1, number of independent serial channels (1..4).
- FIFO_DEPTH, 8, entries per RX FIFO and per TX FIFO; power of two, 2..128.
- DATA_WIDTH, 8, serial byte width (1..8); zero-extended onto the 32-bit CPU bus.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- addr_in  input  32  CPU byte address; [3:2] register select, [5:4] channel select
- rden_in  input  1  CPU load strobe, one cycle per access
- wren_in  input  1  CPU store strobe, one cycle per access
- wdata_in  input  32  CPU store data
- rdata_out  output  32  load data, registered
- serial_in  input  CHANNELS*DATA_WIDTH  RX bytes; channel c at [c*DW +: DW]
- serial_valid_in  input  CHANNELS  RX byte available, per channel
- serial_rden_out  output  CHANNELS  one-cycle pulse: RX byte consumed
- serial_ready_in  input  CHANNELS  TX sink can accept a byte
- serial_out  output  CHANNELS*DATA_WIDTH  TX bytes, registered
- serial_wren_out  output  CHANNELS  one-cycle pulse: serial_out valid

Behaviour:
- Reset, held one or more cycles:
  - All FIFOs are emptied; all RX/TX FSMs go to IDLE.
  - rdata_out, serial_out, serial_rden_out and serial_wren_out are 0.
  - Sticky flags are cleared; CONTROL = 0x3.
  - Reset asserted mid-handshake discards in-flight bytes; no pulse is emitted afterwards.
- Register map per channel (offset = addr_in[3:2]):
  - 0 DATA:
    - Load pops the RX head; the value is DATA_WIDTH bits, zero-extended.
    - Store pushes wdata_in[DW-1:0] into TX.
  - 1 STATUS, read:
    - bit0 rx_not_empty, bit1 tx_not_full, bit2 rx_underflow, bit3 tx_overflow.
    - [15:8] rx_count, [23:16] tx_count; all other bits 0.
  - 1 STATUS, write: W1C on bit2 and bit3; other bits are ignored.
  - 2 CONTROL: bit0 rx_enable, bit1 tx_enable; read/write.
  - 3: reads 0; writes are ignored.
- Channel index >= CHANNELS: reads return 0, writes are ignored, no flags change.
- Load latency: rdata_out updates on the edge after rden_in and holds until the next load.
- FIFO pop and register update happen on that same edge.
- Load from DATA with RX empty: returns 0, sets rx_underflow, FIFO unchanged.
- Store to DATA with TX full: byte dropped, tx_overflow set.
- rden_in and wren_in in the same cycle are serviced independently. Same-channel DATA load and store touch different FIFOs. A STATUS load returns pre-update values.
- A simultaneous push and pop on one FIFO both take effect; the count is unchanged.
  - Pop from empty is never simultaneous with a push in the same cycle: an empty FIFO's pop is rejected even if a push lands in that cycle.
- Counts are clog2(FIFO_DEPTH)+1 bits wide and zero-extended into their 8-bit fields. Pointers wrap modulo FIFO_DEPTH.
- RX FSM per channel, states IDLE, ACK:
  - IDLE to ACK when serial_valid_in && !rx_full && rx_enable. The byte is pushed on that edge and serial_rden_out=1 during ACK.
  - ACK returns to IDLE unconditionally.
  - Peak rate is 1 byte per 2 cycles. The upstream drops or updates valid during ACK.
- TX FSM per channel, states IDLE, SEND:
  - IDLE to SEND when serial_ready_in && !tx_empty && tx_enable. On that edge the head pops into serial_out, and serial_wren_out=1 during SEND.
  - SEND returns to IDLE.
  - serial_out holds its last byte after SEND.
- Clearing an enable bit stops new transfers only; an ACK or SEND already in progress completes.
- Channels are fully independent. No arbitration exists between channels.

Test Plan:
- Reset, then load STATUS ch0 (addr 0x4) -> next cycle rdata_out=0x00000002; CONTROL (0x8) reads 0x3.
- Ch0: serial_valid_in=1 with serial_in=0x41, held 3 cycles -> serial_rden_out pulses twice (cycles 2 and 4), rx_count=2; DATA load returns 0x41.
- Store 0x5A, 0x5B to ch1 DATA (0x10) with serial_ready_in[1]=0 -> tx_count=2, no wren. Raise ready -> serial_wren_out[1] pulses with serial_out=0x5A, then with 0x5B two cycles later.
- Fill ch0 TX with FIFO_DEPTH stores plus one extra, ready low -> STATUS bit3=1, bit1=0, tx_count=8. Store 0x8 to STATUS -> bit3 clears; FIFO contents are intact.
- Load DATA with RX empty -> rdata_out=0, bit2 set. Then, on a FIFO with 1 entry, a CPU pop and a serial push in the same cycle -> rx_count stays 1, and the newer byte is next.
- Assert reset during ch0 ACK with 3 RX entries -> following cycle: serial_rden_out=0, rx_count=0, STATUS=0x2. Address 0x30 with CHANNELS=2 reads 0.
